// File: rtl/fft_feed_pkg.sv
// Shared sizes, read-FSM encoding and beat packing for the FFT frame feeder.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package fft_feed_pkg;

  localparam int FRAME_LEN = 1024;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 16;

  // Read-side FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // A real ADC sample becomes a complex beat with a zero imaginary part
  function automatic logic [31:0] pack_beat(input logic [DATA_W-1:0] sample);
    return {16'd0, sample};
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample store: two FRAME_LEN banks, address {bank, addr}, one write and one read port.
// Latency: read data appears on rd_dat one clock after rd_en is sampled.
// Backpressure: none; the caller schedules reads and writes so they never collide on a bank.
module fft_pingpong_ram
  import fft_feed_pkg::*;
#(
  parameter int AW = ADDR_W + 1,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Registered read port; contents need no reset because the reader tracks validity itself
  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Collects ADC samples into ping-pong frames and streams each full frame to the FFT core.
// Latency: fft_din_valid rises 2 cycles after the final sample of a frame is written; 1 beat/cycle after that.
// Backpressure: fft_din_ready low holds the beat stable; with both banks full, new samples are dropped and overflow pulses.
module fft_frame_feeder
  import fft_feed_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [31:0]       fft_din,
  output logic              fft_din_valid,
  output logic              fft_din_last,
  input  logic              fft_din_ready,
  output logic              frame_start,
  output logic              overflow,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  // Write side
  logic [1:0]        full;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_req;
  logic              wr_en;
  logic              wr_wrap;
  logic              drop;

  // Read side
  logic              rd_bank;
  logic [1:0]        state;
  logic [ADDR_W:0]   rd_cnt;     // reads issued this frame; MSB set once all are issued
  logic              rd_go;
  logic              rd_pend;    // a RAM read was issued last cycle, data is on ram_q now
  logic [DATA_W-1:0] ram_q;

  // Two-entry output buffer: head drives fft_din, skid absorbs the in-flight read
  logic [1:0]        occ;
  logic [2:0]        occ_after;
  logic [DATA_W-1:0] head_dat;
  logic [DATA_W-1:0] skid_dat;
  logic [ADDR_W-1:0] beat_cnt;
  logic              xfer;
  logic              last_xfer;

  assign wr_req    = adc_valid && enable;
  assign wr_en     = rst_n && wr_req && !full[wr_bank];
  assign wr_wrap   = wr_en && (wr_addr == LAST_ADDR);
  assign drop      = wr_req && full[wr_bank];

  assign fft_din_valid = (occ != 2'd0);
  assign fft_din_last  = fft_din_valid && (beat_cnt == LAST_ADDR);
  assign fft_din       = pack_beat(head_dat);
  assign xfer          = fft_din_valid && fft_din_ready;
  assign last_xfer     = xfer && fft_din_last;
  assign busy          = full[0] || full[1] || (state != ST_IDLE);

  // Occupancy the buffer will have after this edge; a new read is only issued if its
  // data is guaranteed a slot next cycle even when the core does not take a beat.
  assign occ_after = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, xfer};
  assign rd_go     = (state == ST_IDLE) ? full[rd_bank]
                                        : (!rd_cnt[ADDR_W] && (occ_after <= 3'd1));

  fft_pingpong_ram #(
    .AW (ADDR_W + 1),
    .DW (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_addr}),
    .wr_dat  (adc_data),
    .rd_en   (rd_go),
    .rd_addr ({rd_bank, rd_cnt[ADDR_W-1:0]}),
    .rd_dat  (ram_q)
  );

  // Writer: fill the current bank, hop banks on the last address, restart when capture drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (!enable) begin
      wr_addr <= '0;
    end else if (wr_en) begin
      wr_addr <= wr_wrap ? '0 : wr_addr + ADDR_W'(1);
      if (wr_wrap) wr_bank <= !wr_bank;
    end
  end

  // Bank-full flags: writer sets, reader clears; the two always target different banks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_wrap && (wr_bank == 1'(b)))        full[b] <= 1'b1;
        else if (last_xfer && (rd_bank == 1'(b))) full[b] <= 1'b0;
      end
    end
  end

  // Read FSM and read-address / beat counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rd_bank  <= 1'b0;
      rd_cnt   <= '0;
      rd_pend  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      rd_pend <= rd_go;
      if (xfer) beat_cnt <= beat_cnt + ADDR_W'(1);
      if (last_xfer) begin
        rd_cnt  <= '0;
        rd_bank <= !rd_bank;
      end else if (rd_go) begin
        rd_cnt  <= rd_cnt + (ADDR_W + 1)'(1);
      end
      case (state)
        ST_IDLE:   if (full[rd_bank]) state <= ST_PRIME;
        ST_PRIME:  state <= ST_STREAM;
        ST_STREAM: if (last_xfer) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Output buffer: RAM data lands in head when it is free or draining, otherwise in skid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      head_dat <= '0;
      skid_dat <= '0;
    end else begin
      occ <= occ_after[1:0];
      case (occ)
        2'd0: begin
          if (rd_pend) head_dat <= ram_q;
        end
        2'd1: begin
          if (rd_pend) begin
            if (xfer) head_dat <= ram_q;
            else      skid_dat <= ram_q;
          end
        end
        default: begin
          if (xfer) begin
            head_dat <= skid_dat;
            skid_dat <= ram_q;
          end
        end
      endcase
    end
  end

  // Status pulses, one cycle after the event that causes them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      overflow    <= drop;
      frame_start <= xfer && (beat_cnt == '0);
    end
  end

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
Transmit side of the FFT sample stream. Collects signed ADC samples into FRAME_LEN-sample frames using a ping-pong buffer. Each complete frame is streamed to the FFT core input as packed complex beats, using a valid/ready/last handshake.
Sits between the ADC capture logic and the FFT core. It is the upstream counterpart of the magnitude calculator, which sits on the FFT output.

Parameters:
FRAME_LEN, 1024, samples per frame; must be a power of two.
ADDR_W, 10, log2(FRAME_LEN).
DATA_W, 16, ADC sample width (signed, two's complement).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
enable  in  1  capture enable; low discards any partial frame being written
adc_data  in  DATA_W  signed sample
adc_valid  in  1  sample strobe, one sample per cycle maximum
fft_din  out  32  packed beat: [31:16]=im=0, [15:0]=re=sample
fft_din_valid  out  1  beat valid
fft_din_last  out  1  high on beat FRAME_LEN-1 of a frame
fft_din_ready  in  1  FFT core accepts the beat
frame_start  out  1  1-cycle pulse when beat 0 of a frame is accepted
overflow  out  1  1-cycle pulse per dropped sample
busy  out  1  high while any bank is full or streaming

Behaviour:
- Reset: clk and rst_n only; reset is synchronous and active-low. On the reset edge, all outputs go to 0, both bank-full flags clear, wr_bank=0, rd_bank=0, wr_addr=0, and the FSM enters IDLE. Reset mid-frame aborts the stream: valid is low after the reset edge and no further beats are issued.
- Handshake: a beat transfers when fft_din_valid && fft_din_ready. While valid is high and ready is low, fft_din and fft_din_last hold stable. Valid never drops mid-frame.
- Write side:
  - On adc_valid && enable && !full[wr_bank]: write mem[wr_bank][wr_addr], then wr_addr++.
  - On writing address FRAME_LEN-1: set full[wr_bank], toggle wr_bank, and set wr_addr=0.
  - On adc_valid && enable && full[wr_bank]: drop the sample and pulse overflow. Blocking only ever occurs at wr_addr=0, so frames stay contiguous.
  - enable=0: wr_addr is forced to 0 and the partial frame is discarded. Full flags and any stream in progress are unaffected.
- Read FSM:
  - IDLE: if full[rd_bank], go to PRIME and issue a RAM read of addr 0.
  - PRIME: one cycle covering the 1-cycle RAM read latency; load the output register; go to STREAM.
  - STREAM: prefetch the next address into a 2-entry skid so that ready held high gives one beat per cycle with no bubbles.
  - On the last beat's handshake: clear full[rd_bank], toggle rd_bank, go to IDLE.
- Latency:
  - fft_din_valid rises 2 cycles after the edge that writes sample FRAME_LEN-1, when the FSM was in IDLE.
  - Between back-to-back frames, valid is low for exactly 2 cycles.
- Simultaneous events: full-set from the writer and full-clear from the reader on the same edge act on different banks, so both take effect.
- Widths: the beat count is ADDR_W bits and wraps. fft_din_last = (beat count == FRAME_LEN-1). Samples are passed unmodified (no scaling).
- busy = full[0] | full[1] | (state != IDLE).

Decomposition:
- Package fft_feed_pkg holds:
  - FRAME_LEN, ADDR_W, DATA_W;
  - the read-FSM state encoding (IDLE, PRIME, STREAM);
  - the beat-pack function: {16'd0, sample}.
- Sub-module fft_pingpong_ram: simple dual-port RAM, 2*FRAME_LEN x DATA_W, address {bank, addr}, 1-cycle registered read.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with adc_valid=1 -> valid, last, overflow and busy all 0; no writes occur.
- Basic frame: enable=1, feed samples -512..511 ramp, ready=1 -> 1024 beats with re=ramp and im=0; last only on beat 1023; frame_start exactly once; valid rises 2 cycles after sample 1023 is written.
- Backpressure: ready toggles pseudo-randomly with 50% duty -> output sequence identical to the ramp, no duplicates or gaps, fft_din stable while stalled.
- Overflow: ready=0, feed 2053 samples -> both banks full after 2048; overflow pulses exactly 5 times. Then ready=1 -> frame 0 then frame 1 streamed with a 2-cycle gap; the next 1024 samples land in bank 0.
- Enable drop: write 500 samples, enable=0 for 1 cycle, then 1024 new samples -> exactly one frame, beat 0 equals the first post-enable sample.
- Reset mid-stream: assert rst_n=0 after beat 300 is accepted -> valid 0 on the next edge, no further beats; after release, a fresh 1024-sample frame streams correctly.
